// File: rtl/mvma_arb_pkg.sv
// Shared types and default constants for the matrix-vector engine arbiter.
package mvma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int W_DEF = 16;
  localparam int M_DEF = 8;
  localparam int N_DEF = 8;

  // Width that can hold every count from 0 up to the larger of the two word counts.
  function automatic int cnt_width(input int m, input int n);
    return $clog2(((m > n) ? m : n) + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner: a lone requester wins, a tie goes to the pointer.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       any,
  output logic       win
);

  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    any = |req;
    win = ptr;
    if (req == 2'b01) begin
      win = 1'b0;
    end else if (req == 2'b10) begin
      win = 1'b1;
    end
  end

endmodule

// File: rtl/mvma_arbiter.sv
// Shares one matrix-vector engine between two requesters, one M-in/N-out request at a time.
// Define ARB_PERF_CNT_EN to add the per-requester completed-request counters gnt_cnt0/gnt_cnt1.
module mvma_arbiter
  import mvma_arb_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int M = M_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  input  logic [W-1:0] req_data0,
  input  logic [W-1:0] req_data1,
  output logic [1:0]   req_ready,
  output logic [1:0]   rsp_valid,
  output logic [W-1:0] rsp_data,
  input  logic [1:0]   rsp_ready,
  output logic         eng_s_valid,
  input  logic         eng_s_ready,
  output logic [W-1:0] eng_data_in,
  input  logic         eng_m_valid,
  output logic         eng_m_ready,
  input  logic [W-1:0] eng_data_out,
  output logic         busy,
  output logic         gnt_id
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]  gnt_cnt0,
  output logic [15:0]  gnt_cnt1
`endif
);

  localparam int            CW       = cnt_width(M, N);
  localparam logic [CW-1:0] IN_LAST  = CW'(M - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(N - 1);

  state_t        state;
  logic          ptr;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          arb_any;
  logic          arb_win;
  logic          in_hs;
  logic          out_hs;

  rr_arb2 u_rr_arb2 (
    .req (req_valid),
    .ptr (ptr),
    .any (arb_any),
    .win (arb_win)
  );

  // The owner is wired straight through to the engine, so handshakes cost no latency.
  always_comb begin
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    eng_s_valid = 1'b0;
    eng_m_ready = 1'b0;
    eng_data_in = gnt_id ? req_data1 : req_data0;
    rsp_data    = eng_data_out;
    if (state == FEED) begin
      eng_s_valid       = req_valid[gnt_id];
      req_ready[gnt_id] = eng_s_ready;
    end
    if (state == DRAIN) begin
      rsp_valid[gnt_id] = eng_m_valid;
      eng_m_ready       = rsp_ready[gnt_id];
    end
  end

  assign in_hs  = eng_s_valid & eng_s_ready;
  assign out_hs = eng_m_valid & eng_m_ready;
  assign busy   = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      gnt_id  <= 1'b0;
      ptr     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_id <= arb_win;
            state  <= FEED;
          end
        end
        FEED: begin
          if (in_hs) begin
            if (in_cnt == IN_LAST) begin
              in_cnt <= '0;
              state  <= DRAIN;
            end else begin
              in_cnt <= in_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (out_cnt == OUT_LAST) begin
              out_cnt <= '0;
              ptr     <= ~gnt_id;
              state   <= IDLE;
            end else begin
              out_cnt <= out_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic req_done;

  assign req_done = (state == DRAIN) && out_hs && (out_cnt == OUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (req_done) begin
      if (!gnt_id && (gnt_cnt0 != 16'hFFFF)) begin
        gnt_cnt0 <= gnt_cnt0 + 16'd1;
      end
      if (gnt_id && (gnt_cnt1 != 16'hFFFF)) begin
        gnt_cnt1 <= gnt_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mvma_arbiter.sv
// Directed bench for mvma_arbiter: grant order, stalls in both phases, and mid-request reset.
module tb_mvma_arbiter;

  localparam int W = 16;
  localparam int M = 8;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [W-1:0] req_data0;
  logic [W-1:0] req_data1;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_ready;
  logic         eng_s_valid;
  logic         eng_s_ready;
  logic [W-1:0] eng_data_in;
  logic         eng_m_valid;
  logic         eng_m_ready;
  logic [W-1:0] eng_data_out;
  logic         busy;
  logic         gnt_id;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]  gnt_cnt0;
  logic [15:0]  gnt_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  mvma_arbiter #(.W(W), .M(M), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data0    (req_data0),
    .req_data1    (req_data1),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .eng_s_valid  (eng_s_valid),
    .eng_s_ready  (eng_s_ready),
    .eng_data_in  (eng_data_in),
    .eng_m_valid  (eng_m_valid),
    .eng_m_ready  (eng_m_ready),
    .eng_data_out (eng_data_out),
    .busy         (busy),
    .gnt_id       (gnt_id)
`ifdef ARB_PERF_CNT_EN
    ,
    .gnt_cnt0     (gnt_cnt0),
    .gnt_cnt1     (gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Hold reset for two edges; returns at a falling edge with the DUT in IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    req_valid    = 2'b00;
    rsp_ready    = 2'b00;
    eng_s_ready  = 1'b0;
    eng_m_valid  = 1'b0;
    req_data0    = '0;
    req_data1    = '0;
    eng_data_out = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full request; called at a falling edge with the DUT in IDLE, returns likewise.
  task automatic run_txn(input logic [1:0] mask, input logic g, input int in_stall,
                         input int out_stall, input logic [W-1:0] in_base,
                         input logic [W-1:0] out_base, input bit keep);
    logic [1:0]   oh;
    logic [W-1:0] exp_w;
    oh          = g ? 2'b10 : 2'b01;
    req_valid   = mask;
    eng_s_ready = 1'b1;
    eng_m_valid = 1'b0;
    rsp_ready   = 2'b00;
    #1;
    checks++;
    if ({busy, req_ready, eng_s_valid} !== 4'b0000)
      $display("FAIL idle_no_handshake: busy/req_ready/eng_s_valid=%b expected 0000",
               {busy, req_ready, eng_s_valid});

    for (int k = 0; k < M; k++) begin
      @(negedge clk);
      exp_w = in_base + W'(k);
      if (g) begin
        req_data1 = exp_w;
        req_data0 = ~exp_w;
      end else begin
        req_data0 = exp_w;
        req_data1 = ~exp_w;
      end
      if (k == in_stall) begin
        eng_s_ready = 1'b0;
        repeat (3) begin
          #1;
          checks++;
          if ({busy, gnt_id, req_ready, eng_s_valid, eng_data_in} !== {1'b1, g, 2'b00, 1'b1, exp_w}) begin
            errors++;
            $display("FAIL feed_stall k=%0d: got busy,gnt,rdy,sv,data=%h expected %h", k,
                     {busy, gnt_id, req_ready, eng_s_valid, eng_data_in},
                     {1'b1, g, 2'b00, 1'b1, exp_w});
          end
          @(negedge clk);
        end
        eng_s_ready = 1'b1;
      end
      #1;
      checks++;
      if ({busy, gnt_id, req_ready, eng_s_valid, eng_data_in} !== {1'b1, g, oh, 1'b1, exp_w}) begin
        errors++;
        $display("FAIL feed k=%0d: got busy,gnt,rdy,sv,data=%h expected %h", k,
                 {busy, gnt_id, req_ready, eng_s_valid, eng_data_in},
                 {1'b1, g, oh, 1'b1, exp_w});
      end
    end

    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      exp_w        = out_base + W'(j);
      eng_m_valid  = 1'b1;
      eng_data_out = exp_w;
      rsp_ready    = 2'b11;
      if (j == out_stall) begin
        rsp_ready = ~oh;
        repeat (3) begin
          #1;
          checks++;
          if ({busy, req_ready, eng_s_valid, rsp_valid, eng_m_ready, rsp_data} !==
              {1'b1, 2'b00, 1'b0, oh, 1'b0, exp_w}) begin
            errors++;
            $display("FAIL drain_stall j=%0d: got busy,rdy,sv,rv,mr,data=%h expected %h", j,
                     {busy, req_ready, eng_s_valid, rsp_valid, eng_m_ready, rsp_data},
                     {1'b1, 2'b00, 1'b0, oh, 1'b0, exp_w});
          end
          @(negedge clk);
        end
        rsp_ready = 2'b11;
      end
      #1;
      checks++;
      if ({busy, req_ready, eng_s_valid, rsp_valid, eng_m_ready, rsp_data} !==
          {1'b1, 2'b00, 1'b0, oh, 1'b1, exp_w}) begin
        errors++;
        $display("FAIL drain j=%0d: got busy,rdy,sv,rv,mr,data=%h expected %h", j,
                 {busy, req_ready, eng_s_valid, rsp_valid, eng_m_ready, rsp_data},
                 {1'b1, 2'b00, 1'b0, oh, 1'b1, exp_w});
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if ({busy, rsp_valid, eng_m_ready, req_ready, eng_s_valid} !== 7'b0) begin
      errors++;
      $display("FAIL back_to_idle: got busy,rv,mr,rdy,sv=%b expected 0000000",
               {busy, rsp_valid, eng_m_ready, req_ready, eng_s_valid});
    end
    eng_m_valid = 1'b0;
    rsp_ready   = 2'b00;
    if (!keep) req_valid = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    reset       = 1'b1;
    req_valid   = 2'b11;
    eng_s_ready = 1'b1;
    eng_m_valid = 1'b1;
    rsp_ready   = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, gnt_id, req_ready, rsp_valid, eng_s_valid, eng_m_ready} !== 8'b0) begin
      errors++;
      $display("FAIL reset_held: got busy,gnt,rdy,rv,sv,mr=%b expected 00000000",
               {busy, gnt_id, req_ready, rsp_valid, eng_s_valid, eng_m_ready});
    end
    do_reset();
    #1;
    checks++;
    if ({busy, gnt_id, req_ready, rsp_valid, eng_s_valid, eng_m_ready} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: got busy,gnt,rdy,rv,sv,mr=%b expected 00000000",
               {busy, gnt_id, req_ready, rsp_valid, eng_s_valid, eng_m_ready});
    end
  endtask

  task automatic test_single_req0();
    run_txn(2'b01, 1'b0, -1, -1, 16'd1, 16'h0100, 1'b0);
  endtask

  // Both requesters held valid from reset: grants alternate 0,1,0 with one IDLE cycle between.
  task automatic test_back_to_back();
    do_reset();
    run_txn(2'b11, 1'b0, -1, -1, 16'h1000, 16'h2000, 1'b1);
    run_txn(2'b11, 1'b1, -1, -1, 16'h3000, 16'h4000, 1'b1);
    run_txn(2'b11, 1'b0, -1, -1, 16'h5000, 16'h6000, 1'b0);
  endtask

  task automatic test_drain_stall();
    run_txn(2'b10, 1'b1, -1, 3, 16'h0040, 16'hFFF8, 1'b0);
  endtask

  task automatic test_feed_stall();
    run_txn(2'b01, 1'b0, 3, -1, 16'h0020, 16'h0300, 1'b0);
  endtask

  // Pointer now favours requester 1; the reset must clear it back to requester 0.
  task automatic test_reset_mid_feed();
    req_valid   = 2'b10;
    eng_s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_data1 = 16'h0700 + 16'(k);
      #1;
      checks++;
      if ({gnt_id, req_ready} !== 3'b110) begin
        errors++;
        $display("FAIL pre_reset_feed k=%0d: got gnt,rdy=%b expected 110", k, {gnt_id, req_ready});
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, gnt_id, req_ready, eng_s_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_feed: got busy,gnt,rdy,sv=%b expected 00000",
               {busy, gnt_id, req_ready, eng_s_valid});
    end
    run_txn(2'b11, 1'b0, -1, -1, 16'h0800, 16'h0900, 1'b0);
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    #1;
    checks++;
    if ({gnt_cnt0, gnt_cnt1} !== 32'h0) begin
      errors++;
      $display("FAIL perf_reset: got %h expected 00000000", {gnt_cnt0, gnt_cnt1});
    end
    run_txn(2'b01, 1'b0, -1, -1, 16'h0010, 16'h0110, 1'b0);
    run_txn(2'b10, 1'b1, -1, -1, 16'h0020, 16'h0120, 1'b0);
    run_txn(2'b01, 1'b0, -1, -1, 16'h0030, 16'h0130, 1'b0);
    run_txn(2'b10, 1'b1, -1, -1, 16'h0040, 16'h0140, 1'b0);
    run_txn(2'b01, 1'b0, -1, -1, 16'h0050, 16'h0150, 1'b0);
    checks++;
    if ({gnt_cnt0, gnt_cnt1} !== {16'd3, 16'd2}) begin
      errors++;
      $display("FAIL perf_counts: got cnt0=%0d cnt1=%0d expected cnt0=3 cnt1=2", gnt_cnt0, gnt_cnt1);
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    req_valid    = 2'b00;
    req_data0    = '0;
    req_data1    = '0;
    rsp_ready    = 2'b00;
    eng_s_ready  = 1'b0;
    eng_m_valid  = 1'b0;
    eng_data_out = '0;

    test_reset();
    test_single_req0();
    test_back_to_back();
    test_drain_stall();
    test_feed_stall();
    test_reset_mid_feed();
`ifdef ARB_PERF_CNT_EN
    test_perf_cnt();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mvma_arbiter.md
MVMA_ARBITER -- requirements
Module: mvma_arbiter

Interface
REQ-001 SHALL have parameter W, default 16: data width of all data ports.
REQ-002 SHALL have parameter M, default 8: input words per request (vector length fed to engine).
REQ-003 SHALL have parameter N, default 8: output words per request (engine results returned).
REQ-004 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port req_valid  input  2  per-requester input-word valid.
REQ-007 SHALL have ports req_data0, req_data1  input  W each  requester input words, signed.
REQ-008 SHALL have port req_ready  output  2  per-requester input-word ready.
REQ-009 SHALL have port rsp_valid  output  2  per-requester result valid.
REQ-010 SHALL have port rsp_data  output  W  result word, shared, qualified by rsp_valid.
REQ-011 SHALL have port rsp_ready  input  2  per-requester result ready.
REQ-012 SHALL have ports eng_s_valid out 1, eng_s_ready in 1, eng_data_in out W: engine input stream.
REQ-013 SHALL have ports eng_m_valid in 1, eng_m_ready out 1, eng_data_out in W: engine output stream.
REQ-014 SHALL have ports busy out 1 (state != IDLE) and gnt_id out 1 (current owner).

Function
REQ-015 SHALL implement FSM IDLE -> FEED -> DRAIN -> IDLE.
REQ-016 IDLE: on any req_valid, SHALL register grant via round-robin and enter FEED next cycle; no handshake in IDLE.
REQ-017 Round-robin: requester not served last wins ties; pointer toggles only on DRAIN completion.
REQ-018 FEED: eng_s_valid = req_valid[gnt]; req_ready[gnt] = eng_s_ready; eng_data_in = req_data[gnt]; other req_ready 0; all combinational, zero latency.
REQ-019 FEED: in_cnt increments per engine-input handshake; on M-th handshake SHALL enter DRAIN, in_cnt cleared.
REQ-020 DRAIN: rsp_valid[gnt] = eng_m_valid; eng_m_ready = rsp_ready[gnt]; rsp_data = eng_data_out; other rsp_valid 0.
REQ-021 DRAIN: out_cnt increments per result handshake; on N-th SHALL enter IDLE, clear out_cnt, update pointer.
REQ-022 Grant SHALL stay locked FEED through DRAIN regardless of either requester dropping valid/ready (stall, not abort).
REQ-023 Outside FEED: eng_s_valid=0, req_ready=0; outside DRAIN: eng_m_ready=0, rsp_valid=0.
REQ-024 Counters SHALL be $clog2(max(M,N)+1) bits, no wrap within one request.
REQ-025 Back-to-back: both requesting continuously SHALL alternate 0,1,0,1 with one IDLE cycle between grants.

Reset
REQ-026 Reset SHALL force IDLE, in_cnt=out_cnt=0, gnt_id=0, pointer favoring requester 0, busy=0, all valid/ready outputs 0.
REQ-027 Reset mid-FEED or mid-DRAIN SHALL abandon transaction; no partial words forwarded the following cycle.

Configuration
REQ-028 With ARB_PERF_CNT_EN defined: 16-bit outputs gnt_cnt0, gnt_cnt1 count completed requests per requester, saturating at 0xFFFF, reset to 0.
REQ-029 Without ARB_PERF_CNT_EN: ports and counters absent; all other behaviour identical.

Structure
REQ-030 Package mvma_arb_pkg SHALL hold state enum (IDLE, FEED, DRAIN) and default constants W=16, M=8, N=8.
REQ-031 Sub-module rr_arb2 SHALL compute 2-way round-robin winner from req_valid and pointer; rest in mvma_arbiter.

Verification
REQ-032 Only req 0 valid, M=8 words 1..8, engine ready -> 8 eng handshakes, DRAIN, 8 results on rsp_valid[0] only.
REQ-033 Both valid from reset -> grant 0 first, then 1, then 0; gnt_id sequence 0,1,0.
REQ-034 Engine eng_s_ready low 3 cycles mid-FEED -> req_ready[gnt] low same cycles, in_cnt holds, no data lost.
REQ-035 rsp_ready[gnt] low during DRAIN -> eng_m_ready low, out_cnt holds, result -5 (0xFFFB) delivered intact later.
REQ-036 Reset asserted after 4th FEED handshake -> next cycle IDLE, busy=0, new request restarts at in_cnt 0.
REQ-037 ARB_PERF_CNT_EN, 3 requests req0, 2 req1 -> gnt_cnt0=3, gnt_cnt1=2.
